// File: rtl/mem_ctrl.sv
// mem_ctrl: sequences external RAM accesses for the memory arbiter.
// Reads return a critical-word-first wrapping burst. Writes are single-word.
// Both are held for programmable wait states.
// Optional feature macro: MEM_CTRL_REFRESH_EN inserts periodic refresh cycles.
module mem_ctrl #(
  parameter int READ_WAIT      = 2,
  parameter int WRITE_WAIT     = 1,
  parameter int BURST_LOG2     = 1,
  parameter int REFRESH_PERIOD = 256,
  parameter int REFRESH_CYCLES = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  request,
  input  logic                  r_w,
  input  logic [22:0]           addr,
  input  logic [31:0]           dataIn,
  output logic                  waitForMem,
  output logic [31:0]           rdData,
  output logic                  rdValid,
  output logic [BURST_LOG2-1:0] rdWordIdx,
  output logic                  mem_ce,
  output logic                  mem_we,
  output logic [22:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  mem_rfsh
);

  localparam int BURST_LEN = 1 << BURST_LOG2;
  localparam int MAXW      = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int WCW       = $clog2(MAXW + 2);

  if (BURST_LOG2 < 1 || READ_WAIT < 0 || WRITE_WAIT < 0 ||
      REFRESH_PERIOD < 2 || REFRESH_CYCLES < 1) begin : g_bad_cfg
    $error("mem_ctrl: unsupported parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_REFRESH} state_t;

  state_t                state_q, state_d;
  logic [BURST_LOG2-1:0] beat_q, beat_d;
  logic [WCW-1:0]        wcnt_q, wcnt_d;
  logic [22:0]           base_q, base_d;
  logic [31:0]           rd_data_d;
  logic                  rd_valid_d;
  logic [BURST_LOG2-1:0] rd_idx_d;
  logic [22:0]           mem_addr_d;
  logic [31:0]           mem_wdata_d;

`ifdef MEM_CTRL_REFRESH_EN
  localparam int RPW = $clog2(REFRESH_PERIOD);
  localparam int RCW = $clog2(REFRESH_CYCLES + 1);

  logic [RPW-1:0] rper_q;
  logic           pending_q;
  logic           pend_clr;
  logic [RCW-1:0] rc_q, rc_d;

  // Free-running refresh timer; a wrap while pending is still set is absorbed.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rper_q    <= '0;
      pending_q <= 1'b0;
    end else if (rper_q == RPW'(REFRESH_PERIOD - 1)) begin
      rper_q    <= '0;
      pending_q <= 1'b1;
    end else begin
      rper_q <= rper_q + RPW'(1);
      if (pend_clr) pending_q <= 1'b0;
    end
  end
`endif

  // Next-state and next-output decode; every output is registered from these.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    wcnt_d      = wcnt_q;
    base_d      = base_q;
    rd_data_d   = rdData;
    rd_valid_d  = 1'b0;
    rd_idx_d    = rdWordIdx;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
`ifdef MEM_CTRL_REFRESH_EN
    pend_clr    = 1'b0;
    rc_d        = rc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (request) begin
          base_d     = addr;
          beat_d     = '0;
          mem_addr_d = addr;
          if (r_w) begin
            state_d     = S_WRITE;
            wcnt_d      = WCW'(WRITE_WAIT);
            mem_wdata_d = dataIn;
          end else begin
            state_d = S_READ;
            wcnt_d  = WCW'(READ_WAIT);
          end
        end
`ifdef MEM_CTRL_REFRESH_EN
        else if (pending_q) begin
          state_d  = S_REFRESH;
          pend_clr = 1'b1;
          rc_d     = RCW'(REFRESH_CYCLES - 1);
        end
`endif
      end
      S_READ: begin
        if (wcnt_q == '0) begin
          rd_data_d  = mem_rdata;
          rd_valid_d = 1'b1;
          rd_idx_d   = base_q[BURST_LOG2-1:0] + beat_q;
          if (beat_q == BURST_LOG2'(BURST_LEN - 1)) begin
            state_d = S_IDLE;
          end else begin
            beat_d     = beat_q + BURST_LOG2'(1);
            wcnt_d     = WCW'(READ_WAIT);
            // Low bits wrap naturally at BURST_LOG2 width.
            mem_addr_d = {base_q[22:BURST_LOG2],
                          base_q[BURST_LOG2-1:0] + beat_q + BURST_LOG2'(1)};
          end
        end else begin
          wcnt_d = wcnt_q - WCW'(1);
        end
      end
      S_WRITE: begin
        if (wcnt_q == '0) state_d = S_IDLE;
        else              wcnt_d  = wcnt_q - WCW'(1);
      end
`ifdef MEM_CTRL_REFRESH_EN
      S_REFRESH: begin
        if (rc_q == '0) state_d = S_IDLE;
        else            rc_d    = rc_q - RCW'(1);
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and output registers; reset clears all of them.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      wcnt_q     <= '0;
      base_q     <= '0;
      rdData     <= '0;
      rdValid    <= 1'b0;
      rdWordIdx  <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_ce     <= 1'b0;
      mem_we     <= 1'b0;
      waitForMem <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      wcnt_q     <= wcnt_d;
      base_q     <= base_d;
      rdData     <= rd_data_d;
      rdValid    <= rd_valid_d;
      rdWordIdx  <= rd_idx_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      mem_ce     <= (state_d == S_READ) || (state_d == S_WRITE);
      mem_we     <= (state_d == S_WRITE);
      waitForMem <= (state_d != S_IDLE);
    end
  end

`ifdef MEM_CTRL_REFRESH_EN
  // Refresh cycle counter and registered refresh strobe.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rc_q     <= '0;
      mem_rfsh <= 1'b0;
    end else begin
      rc_q     <= rc_d;
      mem_rfsh <= (state_d == S_REFRESH);
    end
  end
`else
  assign mem_rfsh = 1'b0;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl in its default configuration.
module tb_mem_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        request;
  logic        r_w;
  logic [22:0] addr;
  logic [31:0] dataIn;
  logic        waitForMem;
  logic [31:0] rdData;
  logic        rdValid;
  logic [0:0]  rdWordIdx;
  logic        mem_ce;
  logic        mem_we;
  logic [22:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rfsh;

  int checks = 0;
  int errors = 0;

  mem_ctrl #(
    .READ_WAIT(2),
    .WRITE_WAIT(1),
    .BURST_LOG2(1),
    .REFRESH_PERIOD(256),
    .REFRESH_CYCLES(4)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .request(request),
    .r_w(r_w),
    .addr(addr),
    .dataIn(dataIn),
    .waitForMem(waitForMem),
    .rdData(rdData),
    .rdValid(rdValid),
    .rdWordIdx(rdWordIdx),
    .mem_ce(mem_ce),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_rfsh(mem_rfsh)
  );

  always #5 CLK = ~CLK;

  // RAM model: read data is the address tagged with 9'h1A5 in the top bits.
  assign mem_rdata = {9'h1A5, mem_addr};

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic rw, input logic [22:0] a, input logic [31:0] d);
    request = 1'b1;
    r_w     = rw;
    addr    = a;
    dataIn  = d;
  endtask

  task automatic release_req();
    request = 1'b0;
    r_w     = 1'b0;
    addr    = '0;
    dataIn  = '0;
  endtask

  initial begin
    logic ok_rf;
    logic ok_wt;
    RESET = 1'b1;
    release_req();

    // Reset state
    tick();
    tick();
    chk("rst_wait", {31'd0, waitForMem}, 32'd0);
    chk("rst_ce",   {31'd0, mem_ce},     32'd0);
    chk("rst_we",   {31'd0, mem_we},     32'd0);
    chk("rst_vld",  {31'd0, rdValid},    32'd0);
    chk("rst_rd",   rdData,              32'd0);
    chk("rst_addr", {9'd0, mem_addr},    32'd0);
    chk("rst_wd",   mem_wdata,           32'd0);
    chk("rst_rfsh", {31'd0, mem_rfsh},   32'd0);
    RESET = 1'b0;
    tick();

    // Read addr 5: beat 0 at addr 5 (valid cycle 4), beat 1 wraps to addr 4 (valid cycle 7)
    pulse(1'b0, 23'h000005, 32'h0);
    tick();
    release_req();
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("rd_c%0d_ce", c),   {31'd0, mem_ce},     (c <= 6) ? 32'd1 : 32'd0);
      chk($sformatf("rd_c%0d_wait", c), {31'd0, waitForMem}, (c <= 6) ? 32'd1 : 32'd0);
      chk($sformatf("rd_c%0d_addr", c), {9'd0, mem_addr},    (c <= 3) ? 32'h5 : 32'h4);
      chk($sformatf("rd_c%0d_vld", c),  {31'd0, rdValid},    (c == 4 || c == 7) ? 32'd1 : 32'd0);
      chk($sformatf("rd_c%0d_we", c),   {31'd0, mem_we},     32'd0);
      if (c == 4) begin
        chk("rd_b0_data", rdData, 32'hD2800005);
        chk("rd_b0_idx",  {31'd0, rdWordIdx}, 32'd1);
      end
      if (c == 7) begin
        chk("rd_b1_data", rdData, 32'hD2800004);
        chk("rd_b1_idx",  {31'd0, rdWordIdx}, 32'd0);
        // Back-to-back write issued in the first idle cycle
        pulse(1'b1, 23'h012345, 32'hDEADBEEF);
      end
      if (c < 7) tick();
    end

    // Write: mem_we in cycles 1-2, idle at cycle 3
    tick();
    release_req();
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("wr_c%0d_we", c),   {31'd0, mem_we},     (c <= 2) ? 32'd1 : 32'd0);
      chk($sformatf("wr_c%0d_ce", c),   {31'd0, mem_ce},     (c <= 2) ? 32'd1 : 32'd0);
      chk($sformatf("wr_c%0d_wait", c), {31'd0, waitForMem}, (c <= 2) ? 32'd1 : 32'd0);
      chk($sformatf("wr_c%0d_vld", c),  {31'd0, rdValid},    32'd0);
      if (c <= 2) begin
        chk($sformatf("wr_c%0d_addr", c), {9'd0, mem_addr}, 32'h00012345);
        chk($sformatf("wr_c%0d_wd", c),   mem_wdata,        32'hDEADBEEF);
      end
      if (c < 3) tick();
    end

    // Read addr 2 with a write request injected mid-burst (must be ignored)
    pulse(1'b0, 23'h000002, 32'h0);
    tick();
    release_req();
    for (int c = 1; c <= 7; c++) begin
      if (c == 2) pulse(1'b1, 23'h7FFFFF, 32'h12345678);
      if (c == 3) release_req();
      chk($sformatf("ig_c%0d_we", c),   {31'd0, mem_we},     32'd0);
      chk($sformatf("ig_c%0d_addr", c), {9'd0, mem_addr},    (c <= 3) ? 32'h2 : 32'h3);
      chk($sformatf("ig_c%0d_vld", c),  {31'd0, rdValid},    (c == 4 || c == 7) ? 32'd1 : 32'd0);
      chk($sformatf("ig_c%0d_wait", c), {31'd0, waitForMem}, (c <= 6) ? 32'd1 : 32'd0);
      if (c == 4) begin
        chk("ig_b0_data", rdData, 32'hD2800002);
        chk("ig_b0_idx",  {31'd0, rdWordIdx}, 32'd0);
      end
      if (c == 7) begin
        chk("ig_b1_data", rdData, 32'hD2800003);
        chk("ig_b1_idx",  {31'd0, rdWordIdx}, 32'd1);
      end
      tick();
    end

    // Read addr 5 aborted by RESET during cycle 4
    pulse(1'b0, 23'h000005, 32'h0);
    tick();
    release_req();
    tick();
    tick();
    tick();
    chk("ab_c4_vld", {31'd0, rdValid}, 32'd1);
    RESET = 1'b1;
    tick();
    chk("ab_ce",   {31'd0, mem_ce},     32'd0);
    chk("ab_we",   {31'd0, mem_we},     32'd0);
    chk("ab_wait", {31'd0, waitForMem}, 32'd0);
    chk("ab_vld",  {31'd0, rdValid},    32'd0);
    chk("ab_rd",   rdData,              32'd0);
    chk("ab_idx",  {31'd0, rdWordIdx},  32'd0);
    chk("ab_addr", {9'd0, mem_addr},    32'd0);
    chk("ab_wd",   mem_wdata,           32'd0);
    RESET = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("ab_post%0d_vld", c), {31'd0, rdValid},    32'd0);
      chk($sformatf("ab_post%0d_ce", c),  {31'd0, mem_ce},     32'd0);
      chk($sformatf("ab_post%0d_wait", c), {31'd0, waitForMem}, 32'd0);
    end

    // Accepted again after the abort: waitForMem rises the next cycle
    pulse(1'b1, 23'h000010, 32'hCAFEF00D);
    tick();
    release_req();
    chk("post_wr_wait", {31'd0, waitForMem}, 32'd1);
    chk("post_wr_we",   {31'd0, mem_we},     32'd1);
    chk("post_wr_wd",   mem_wdata,           32'hCAFEF00D);
    tick();
    tick();
    chk("post_wr_idle", {31'd0, waitForMem}, 32'd0);

    // Long idle stretch: no refresh in the default build, bus stays idle
    ok_rf = 1'b1;
    ok_wt = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (mem_rfsh !== 1'b0)   ok_rf = 1'b0;
      if (waitForMem !== 1'b0) ok_wt = 1'b0;
    end
    chk("idle_rfsh_low", {31'd0, ok_rf}, 32'd1);
    chk("idle_wait_low", {31'd0, ok_wt}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller that sits between the memory arbiter and the external RAM. It accepts one-cycle request pulses (read line fill or single-word write) and sequences the RAM control lines with programmable wait states. For reads it returns a critical-word-first burst. It drives `waitForMem` back to the arbiter and, optionally, inserts periodic refresh cycles.

## Interface
Parameters:
- READ_WAIT, 2, extra cycles each read beat is held (beat length = READ_WAIT+1)
- WRITE_WAIT, 1, extra cycles a write is held (length = WRITE_WAIT+1)
- BURST_LOG2, 1, log2 of read burst length (BURST_LEN = 2^BURST_LOG2 words)
- REFRESH_PERIOD, 256, cycles between refresh requests
- REFRESH_CYCLES, 4, length of one refresh operation

Ports (reset RESET, synchronous, active-high; clock CLK):
- CLK  in  1  clock
- RESET  in  1  synchronous active-high reset
- request  in  1  one-cycle request pulse from arbiter
- r_w  in  1  1 = write, 0 = read; sampled with request
- addr  in  23  word address; sampled with request
- dataIn  in  32  write data; sampled with request
- waitForMem  out  1  1 = busy; 0 = idle and accepting
- rdData  out  32  registered read word
- rdValid  out  1  one-cycle strobe, rdData valid
- rdWordIdx  out  BURST_LOG2  low address bits of the word on rdData
- mem_ce  out  1  RAM chip enable
- mem_we  out  1  RAM write enable
- mem_addr  out  23  RAM address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data
- mem_rfsh  out  1  RAM refresh strobe

## Operation
- States: IDLE, READ, WRITE, REFRESH.
- IDLE, request=1, r_w=0: latch addr and go to READ. Beat counter = 0, wait counter = READ_WAIT.
- IDLE, request=1, r_w=1: latch addr and dataIn, go to WRITE, wait counter = WRITE_WAIT.
- Requests in any state other than IDLE are ignored, with no side effects.
- READ:
  - mem_ce=1, mem_addr = {base[22:BURST_LOG2], base[BURST_LOG2-1:0]+beat}, with wrap modulo BURST_LEN.
  - The wait counter decrements each cycle. At 0, mem_rdata is registered into rdData, rdValid=1 and rdWordIdx = that beat's low bits.
  - The beat then advances and the wait counter reloads.
  - After beat BURST_LEN-1, go to IDLE.
- WRITE:
  - mem_ce=1, mem_we=1, mem_addr = latched addr, mem_wdata = latched data.
  - On wait counter 0, go to IDLE.
- waitForMem = 1 in READ, WRITE and REFRESH; 0 in IDLE.
- Reset values: state IDLE; every output 0, including rdData, mem_addr and mem_wdata.
- RESET mid-operation: abort immediately. No further rdValid; mem_ce/mem_we are 0 in the next cycle.

## Timing
- Cycle 0 = the cycle with request=1 in IDLE.
- Read:
  - mem_ce is high from cycle 1 to BURST_LEN*(READ_WAIT+1).
  - rdValid for beat k is high in cycle 1+(k+1)*(READ_WAIT+1).
  - The last rdValid coincides with the first cycle of waitForMem=0, so the arbiter's access-state write gate still covers it.
- Write: mem_we is high in cycles 1..1+WRITE_WAIT. waitForMem is high for the same cycles and low at cycle 2+WRITE_WAIT.
- waitForMem rises in cycle 1, the edge after request is sampled.
- Back-to-back requests: a new request is accepted in the first cycle waitForMem=0.
- Between the pulses, mem_ce, mem_we and rdValid are registered outputs with no combinational path from request.

## Configuration
- MEM_CTRL_REFRESH_EN defined:
  - A counter increments every cycle. At REFRESH_PERIOD-1 it sets `pending` and wraps to 0.
  - In IDLE with pending=1 and request=0: enter REFRESH, clear pending, and hold mem_rfsh=1 and waitForMem=1 for REFRESH_CYCLES cycles, then return to IDLE.
  - If request and pending occur together in IDLE, the request wins and refresh follows that access.
  - If a second period elapses while pending is still set, it does not queue a second refresh.
- Not defined: counter and REFRESH state are absent; mem_rfsh tied 0.

## Test plan
- Read with defaults, addr=0x000005, mem_rdata = address-derived pattern:
  - mem_addr is 0x000005 in cycles 1–3 and 0x000004 in cycles 4–6.
  - rdValid in cycles 4 and 7, with rdWordIdx 1 then 0.
  - waitForMem low at cycle 7.
- Write addr=0x12345, dataIn=0xDEADBEEF:
  - mem_we high in cycles 1–2 with that addr/data.
  - waitForMem low at cycle 3; no rdValid.
- Request pulse on the cycle after waitForMem drops: accepted, and waitForMem is high again the next cycle. A request pulse in the middle of a read: ignored, burst unchanged.
- RESET asserted in cycle 4 of a read: all outputs 0 from the next cycle, no further rdValid, state IDLE.
- MEM_CTRL_REFRESH_EN, idle bus:
  - mem_rfsh high for 4 cycles every 256 cycles.
  - A request arriving during refresh is ignored.
  - A request at the same edge refresh becomes due is serviced first, and refresh starts immediately after.
- Without MEM_CTRL_REFRESH_EN: 1000 idle cycles give mem_rfsh=0 and waitForMem=0 throughout.
